// File: rtl/cpu_controller.sv
// Instruction sequencer for the 16-bit datapath: fetches into IR, keeps the PC,
// and walks a Moore FSM that drives every datapath strobe and memory command.
module cpu_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] datapath_out,
  output logic [7:0]  mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  PC,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_RESET  = 5'd0,  S_FETCH1 = 5'd1,  S_FETCH2 = 5'd2,  S_UPDATE = 5'd3,
    S_DECODE = 5'd4,  S_WIMM   = 5'd5,  S_GETA   = 5'd6,  S_GETB   = 5'd7,
    S_ALU    = 5'd8,  S_WC     = 5'd9,  S_ADDR   = 5'd10, S_LDA    = 5'd11,
    S_RD1    = 5'd12, S_RD2    = 5'd13, S_GETD   = 5'd14, S_PASS   = 5'd15,
    S_MWR    = 5'd16, S_HALT   = 5'd17
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] ir_r;
  logic [7:0]  pc_r;
  logic [7:0]  dar_r;

  logic [2:0] opcode_s, rn_s, rd_s, rm_s;
  logic [1:0] op_s, sh_s;
  logic is_movi_s, is_movr_s, is_alu_s, is_cmp_s, is_mvn_s;
  logic is_ldr_s, is_str_s, is_halt_s;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  assign opcode_s = ir_r[15:13];
  assign op_s     = ir_r[12:11];
  assign rn_s     = ir_r[10:8];
  assign rd_s     = ir_r[7:5];
  assign sh_s     = ir_r[4:3];
  assign rm_s     = ir_r[2:0];

  assign is_movi_s = (opcode_s == 3'b110) && (op_s == 2'b10);
  assign is_movr_s = (opcode_s == 3'b110) && (op_s == 2'b00);
  assign is_alu_s  = (opcode_s == 3'b101);
  assign is_cmp_s  = is_alu_s && (op_s == 2'b01);
  assign is_mvn_s  = is_alu_s && (op_s == 2'b11);
  assign is_ldr_s  = (opcode_s == 3'b011) && (op_s == 2'b00);
  assign is_str_s  = (opcode_s == 3'b100) && (op_s == 2'b00);
  assign is_halt_s = (opcode_s == 3'b111);

  // Field-derived controls depend on IR alone, never on inputs.
  assign shift  = (is_movr_s || is_alu_s) ? sh_s : 2'b00;
  assign ALUop  = is_alu_s ? op_s : 2'b00;
  assign sximm8 = sext8(ir_r[7:0]);
  assign sximm5 = sext5(ir_r[4:0]);
  assign PC     = pc_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // IR, PC and data-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r  <= 16'h0000;
      pc_r  <= 8'h00;
      dar_r <= 8'h00;
    end else begin
      if (state_r == S_FETCH2) ir_r  <= mem_rdata;
      if (state_r == S_UPDATE) pc_r  <= pc_r + 8'd1;
      if (state_r == S_LDA)    dar_r <= datapath_out[7:0];
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_nxt_s = S_RESET;
    case (state_r)
      S_RESET:  state_nxt_s = S_FETCH1;
      S_FETCH1: state_nxt_s = S_FETCH2;
      S_FETCH2: state_nxt_s = S_UPDATE;
      S_UPDATE: state_nxt_s = S_DECODE;
      S_DECODE: begin
        if (is_movi_s) begin
          state_nxt_s = S_WIMM;
        end else if (is_movr_s || is_mvn_s) begin
          state_nxt_s = S_GETB;
        end else if (is_alu_s || is_ldr_s || is_str_s) begin
          state_nxt_s = S_GETA;
        end else if (is_halt_s) begin
          state_nxt_s = S_HALT;
        end else begin
          state_nxt_s = S_FETCH1;
        end
      end
      S_WIMM:   state_nxt_s = S_FETCH1;
      S_GETA: begin
        if (is_ldr_s || is_str_s) begin
          state_nxt_s = S_ADDR;
        end else begin
          state_nxt_s = S_GETB;
        end
      end
      S_GETB:   state_nxt_s = S_ALU;
      S_ALU: begin
        if (is_cmp_s) begin
          state_nxt_s = S_FETCH1;
        end else begin
          state_nxt_s = S_WC;
        end
      end
      S_WC:     state_nxt_s = S_FETCH1;
      S_ADDR:   state_nxt_s = S_LDA;
      S_LDA: begin
        if (is_ldr_s) begin
          state_nxt_s = S_RD1;
        end else begin
          state_nxt_s = S_GETD;
        end
      end
      S_RD1:    state_nxt_s = S_RD2;
      S_RD2:    state_nxt_s = S_FETCH1;
      S_GETD:   state_nxt_s = S_PASS;
      S_PASS:   state_nxt_s = S_MWR;
      S_MWR:    state_nxt_s = S_FETCH1;
      S_HALT:   state_nxt_s = S_HALT;
      default:  state_nxt_s = S_RESET;
    endcase
  end

  // Moore output decode from state and IR fields.
  always_comb begin
    mem_addr  = 8'h00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    readnum   = 3'b000;
    writenum  = 3'b000;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    halted    = 1'b0;
    case (state_r)
      S_FETCH1, S_FETCH2: begin
        mem_read = 1'b1;
        mem_addr = pc_r;
      end
      S_WIMM: begin
        vsel     = 2'b01;
        writenum = rn_s;
        write    = 1'b1;
      end
      S_GETA: begin
        readnum = rn_s;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = rm_s;
        loadb   = 1'b1;
      end
      S_ALU: begin
        if (is_cmp_s) begin
          loads = 1'b1;
        end else begin
          loadc = 1'b1;
          asel  = is_movr_s;
        end
      end
      S_WC: begin
        vsel     = 2'b11;
        writenum = rd_s;
        write    = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_RD1: begin
        mem_read = 1'b1;
        mem_addr = dar_r;
      end
      S_RD2: begin
        mem_read = 1'b1;
        mem_addr = dar_r;
        writenum = rd_s;
        write    = 1'b1;
      end
      S_GETD: begin
        readnum = rd_s;
        loadb   = 1'b1;
      end
      S_PASS: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MWR: begin
        mem_write = 1'b1;
        mem_addr  = dar_r;
      end
      S_HALT:   halted = 1'b1;
      default:  halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: per-instruction cycle-script model checked every
// cycle, plus directed literal expectations from hand-decoded programs.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic [15:0] datapath_out = 16'h1234;
  logic [7:0]  mem_addr, PC;
  logic        mem_read, mem_write;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop, vsel;
  logic        write, loada, loadb, loadc, loads, asel, bsel, halted;
  logic [15:0] sximm8, sximm5;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .datapath_out(datapath_out),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .PC(PC),
    .readnum(readnum), .writenum(writenum), .shift(shift), .ALUop(ALUop),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .sximm8(sximm8), .sximm5(sximm5),
    .halted(halted)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic        rd, wr;
    logic [7:0]  pc;
    logic [2:0]  rnum, wnum;
    logic [1:0]  sh, aop;
    logic        we, la, lb, lc, ls, asl, bsl;
    logic [1:0]  vs;
    logic [15:0] s8, s5;
    logic        hlt;
  } outs_t;

  logic [15:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;
  outs_t       exp_q[$];
  logic [7:0]  m_pc, m_dar;
  logic [15:0] m_ir;
  bit          m_halt;

  // Outputs that follow from the instruction word and PC alone.
  function automatic outs_t base(input logic [15:0] ir, input logic [7:0] pc);
    outs_t o;
    logic [2:0] opc;
    opc = ir[15:13];
    o = '0;
    o.pc = pc;
    o.s8 = {{8{ir[7]}}, ir[7:0]};
    o.s5 = {{11{ir[4]}}, ir[4:0]};
    if (opc == 3'b101 || (opc == 3'b110 && ir[12:11] == 2'b00)) o.sh = ir[4:3];
    if (opc == 3'b101) o.aop = ir[12:11];
    return o;
  endfunction

  // Append the cycle-by-cycle expectations for the next instruction.
  task automatic expand();
    outs_t o;
    logic [2:0] opc;
    logic [1:0] op;
    o = base(m_ir, m_pc);
    o.rd = 1'b1;
    o.addr = m_pc;
    exp_q.push_back(o);
    exp_q.push_back(o);
    m_ir = mem[m_pc];
    exp_q.push_back(base(m_ir, m_pc));
    m_pc = m_pc + 8'd1;
    exp_q.push_back(base(m_ir, m_pc));
    opc = m_ir[15:13];
    op  = m_ir[12:11];
    if (opc == 3'b110 && op == 2'b10) begin
      o = base(m_ir, m_pc); o.wnum = m_ir[10:8]; o.vs = 2'b01; o.we = 1'b1; exp_q.push_back(o);
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      if (opc == 3'b101 && op != 2'b11) begin
        o = base(m_ir, m_pc); o.rnum = m_ir[10:8]; o.la = 1'b1; exp_q.push_back(o);
      end
      o = base(m_ir, m_pc); o.rnum = m_ir[2:0]; o.lb = 1'b1; exp_q.push_back(o);
      o = base(m_ir, m_pc);
      if (opc == 3'b101 && op == 2'b01) begin
        o.ls = 1'b1;
      end else begin
        o.lc = 1'b1;
        o.asl = (opc == 3'b110);
      end
      exp_q.push_back(o);
      if (!(opc == 3'b101 && op == 2'b01)) begin
        o = base(m_ir, m_pc); o.wnum = m_ir[7:5]; o.vs = 2'b11; o.we = 1'b1; exp_q.push_back(o);
      end
    end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
      o = base(m_ir, m_pc); o.rnum = m_ir[10:8]; o.la = 1'b1; exp_q.push_back(o);
      o = base(m_ir, m_pc); o.bsl = 1'b1; o.lc = 1'b1; exp_q.push_back(o);
      exp_q.push_back(base(m_ir, m_pc));
      m_dar = datapath_out[7:0];
      if (opc == 3'b011) begin
        o = base(m_ir, m_pc); o.rd = 1'b1; o.addr = m_dar; exp_q.push_back(o);
        o.we = 1'b1; o.wnum = m_ir[7:5]; exp_q.push_back(o);
      end else begin
        o = base(m_ir, m_pc); o.rnum = m_ir[7:5]; o.lb = 1'b1; exp_q.push_back(o);
        o = base(m_ir, m_pc); o.asl = 1'b1; o.lc = 1'b1; exp_q.push_back(o);
        o = base(m_ir, m_pc); o.wr = 1'b1; o.addr = m_dar; exp_q.push_back(o);
      end
    end else if (opc == 3'b111) begin
      m_halt = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // Memory: data valid in the second consecutive read cycle.
  initial begin
    bit prev_rd;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_read && prev_rd) mem_rdata = mem[mem_addr];
      else mem_rdata = 16'hDEAD;
      prev_rd = mem_read;
    end
  end

  // Per-cycle compare against the model.
  initial begin
    outs_t act, want;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_pc = 8'h00; m_ir = 16'h0000; m_dar = 8'h00; m_halt = 1'b0;
        want = base(16'h0000, 8'h00);
      end else begin
        if (exp_q.size() == 0) begin
          if (m_halt) begin
            want = base(m_ir, m_pc);
            want.hlt = 1'b1;
            exp_q.push_back(want);
          end else begin
            expand();
          end
        end
        want = exp_q.pop_front();
      end
      act = {mem_addr, mem_read, mem_write, PC, readnum, writenum, shift, ALUop,
             write, loada, loadb, loadc, loads, asel, bsel, vsel, sximm8, sximm5, halted};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL outputs t=%0t got %h expected %h", $time, act, want);
      end
    end
  end

  task automatic load_prog(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2);
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = i0; mem[1] = i1; mem[2] = i2;
  endtask

  task automatic restart();
    @(negedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // MOV imm, negative imm, HALT
    load_prog(16'hD105, 16'hD2FF, 16'hE000);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("c1_read", {mem_read, mem_addr}, {1'b1, 8'h00});
    @(negedge clk); chk("c2_read", {mem_read, mem_addr}, {1'b1, 8'h00});
    repeat (3) @(negedge clk);
    chk("movi_wr", {write, writenum, vsel}, {1'b1, 3'd1, 2'b01});
    chk("movi_imm", sximm8, 16'h0005);
    chk("movi_pc", PC, 8'h01);
    @(negedge clk); chk("fetch1", {mem_read, mem_addr}, {1'b1, 8'h01});
    repeat (4) @(negedge clk);
    chk("neg_imm", {write, writenum, sximm8}, {1'b1, 3'd2, 16'hFFFF});
    repeat (5) @(negedge clk); chk("halted", halted, 1'b1);
    repeat (25) @(negedge clk);
    chk("halt_idle", {halted, mem_read, mem_write}, {1'b1, 1'b0, 1'b0});

    // ADD with shift then CMP
    load_prog(16'hA1A9, 16'hA9A1, 16'hE000);
    restart();
    repeat (5) @(negedge clk); chk("add_geta", {loada, readnum}, {1'b1, 3'd1});
    @(negedge clk); chk("add_getb", {loadb, readnum}, {1'b1, 3'd1});
    @(negedge clk); chk("add_alu", {loadc, ALUop, shift}, {1'b1, 2'b00, 2'b01});
    @(negedge clk); chk("add_wc", {write, writenum, vsel}, {1'b1, 3'd5, 2'b11});
    repeat (7) @(negedge clk);
    chk("cmp_alu", {loads, ALUop, loadc, write}, {1'b1, 2'b01, 1'b0, 1'b0});
    @(negedge clk); chk("cmp_next", {mem_read, mem_addr}, {1'b1, 8'h02});

    // LDR R3,[R1,#2] then STR R3,[R1,#2]
    load_prog(16'h6162, 16'h8162, 16'hE000);
    datapath_out = 16'h0007;
    restart();
    repeat (8) @(negedge clk); chk("ldr_rd1", {mem_read, mem_addr}, {1'b1, 8'h07});
    @(negedge clk); chk("ldr_rd2", {mem_read, mem_addr, write, writenum, vsel},
                        {1'b1, 8'h07, 1'b1, 3'd3, 2'b00});
    repeat (10) @(negedge clk);
    chk("str_mwr", {mem_write, mem_read, mem_addr}, {1'b1, 1'b0, 8'h07});
    @(negedge clk); chk("str_once", mem_write, 1'b0);

    // Reset pulse mid-ADD
    load_prog(16'hA1A9, 16'hE000, 16'hE000);
    datapath_out = 16'h1234;
    restart();
    repeat (6) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("rst_strobes", {loadc, loada, loadb, loads, write, mem_read, mem_write, asel, bsel},
           9'd0);
    chk("rst_pc", {PC, mem_addr}, 16'h0000);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("rst_refetch", {mem_read, mem_addr}, {1'b1, 8'h00});
    repeat (10) @(negedge clk);

    // 256 NOPs: PC wraps
    load_prog(16'h0000, 16'h0000, 16'h0000);
    restart();
    repeat (1020) @(negedge clk); chk("pc_ff", PC, 8'hFF);
    repeat (4) @(negedge clk); chk("pc_wrap", PC, 8'h00);
    @(negedge clk); chk("wrap_fetch", {mem_read, mem_addr}, {1'b1, 8'h00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction-sequencing stage sitting directly upstream of the 16-bit `datapath`. It fetches 16-bit instructions from memory into an instruction register and keeps the program counter. It decodes each instruction and walks a Moore state machine that drives every datapath control strobe, register index, immediate and memory command. Datapath results return only through `datapath_out`, which serves as the load/store address source.

## Interface
- No parameters. Widths are fixed: 16-bit data, 8-bit PC and memory address, 8 registers.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_rdata` in 16: memory read data. Valid in the second cycle of a read; instruction or load data.
- `datapath_out` in 16: datapath C register; bits [7:0] used as the load/store address.
- `mem_addr` out 8: memory address; PC during fetch, DAR during load/store, else 0.
- `mem_read` out 1 / `mem_write` out 1: memory commands; never both high.
- `PC` out 8: program counter.
- `readnum`, `writenum` out 3: register indices.
- `shift` out 2, `ALUop` out 2: shifter and ALU controls.
- `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel` out 1 each: datapath strobes and mux selects.
- `vsel` out 2: write-back source (00 mdata, 01 sximm8, 10 PC, 11 C).
- `sximm8` out 16, `sximm5` out 16: sign-extended IR[7:0] and IR[4:0].
- `halted` out 1: high while in HALT.

## Operation
- Instruction fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Supported instructions:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{sh}
  - 101/00: ADD
  - 101/01: CMP
  - 101/10: AND
  - 101/11: MVN
  - 011/00: LDR Rd,[Rn,#imm5]
  - 100/00: STR Rd,[Rn,#imm5]
  - 111/xx: HALT
  - Any other encoding is a NOP.
- Registers:
  - IR (16 bit).
  - PC (8 bit; increments wrap FF→00).
  - DAR (8 bit data address).
  - State register.
- Outputs are decoded from state and IR only, with no input-to-output combinational path.
- Any strobe not listed for a state is 0; indices and selects default to 0.
- `shift` = sh for MOV-reg/ALU instructions and 00 for LDR/STR. `ALUop` = op for opcode 101, else 00.
- States and actions:
  - RESET: all strobes 0 → FETCH1.
  - FETCH1: mem_read=1, mem_addr=PC → FETCH2.
  - FETCH2: mem_read=1, mem_addr=PC; IR←mem_rdata → UPDATE.
  - UPDATE: PC←PC+1 → DECODE.
  - DECODE: no strobes. Branch: MOV imm→WIMM; MOV reg/MVN→GETB; ADD/AND/CMP/LDR/STR→GETA; HALT→HALT; NOP→FETCH1.
  - WIMM: vsel=01, writenum=Rn, write=1 → FETCH1.
  - GETA: readnum=Rn, loada=1. LDR/STR→ADDR, else →GETB.
  - GETB: readnum=Rm, loadb=1 → ALU.
  - ALU:
    - MOV reg: asel=1, loadc=1.
    - CMP: loads=1, loadc=0 → FETCH1.
    - ADD/AND/MVN: loadc=1.
    - All except CMP → WC.
  - WC: vsel=11, writenum=Rd, write=1 → FETCH1.
  - ADDR: bsel=1, ALUop=00, loadc=1 → LDA.
  - LDA: DAR←datapath_out[7:0]. LDR→RD1, STR→GETD.
  - RD1: mem_read=1, mem_addr=DAR → RD2.
  - RD2: mem_read=1, mem_addr=DAR, vsel=00, writenum=Rd, write=1 → FETCH1.
  - GETD: readnum=Rd, loadb=1 → PASS.
  - PASS: asel=1, bsel=0, ALUop=00, loadc=1 → MWR.
  - MWR: mem_write=1, mem_addr=DAR; store data is datapath_out, supplied externally → FETCH1.
  - HALT: halted=1, no strobes; only reset leaves.

## Timing
- Reset (asynchronous, immediate on rst_n low):
  - State=RESET, PC=00, IR=0000, DAR=00.
  - All strobes, mem_read, mem_write and halted = 0.
  - mem_addr=00, sximm8=sximm5=0000.
- Reset asserted mid-instruction aborts it the same instant. No partial write occurs after rst_n falls.
- First FETCH1 is the first rising edge after rst_n rises.
- Memory read latency is fixed: address presented in cycle N, data sampled at the end of cycle N+1.
- Cycles per instruction, FETCH1 through the last state:
  - MOV imm: 5
  - MOV reg, MVN: 7
  - CMP: 7
  - ADD, AND: 8
  - LDR: 9
  - STR: 10
  - NOP: 4
  - HALT: 4, then stays in HALT.
- PC shows the incremented value from the cycle after UPDATE onward.
- Address arithmetic is 16-bit in the datapath; only bits [7:0] are kept, so the address wraps modulo 256.

## Test plan
- Reset then MOV imm:
  - Memory[0]=D105 (MOV R1,#5).
  - Release reset; expect mem_read on cycles 1–2 with addr 00.
  - Cycle 5: write=1, writenum=1, vsel=01, sximm8=0005. PC=01.
- Negative immediate:
  - IR=D2FF (MOV R2,#-1).
  - Expect sximm8=FFFF, write asserted once, next fetch at addr 01.
- ADD with shift:
  - IR=A1A9 (ADD R5,R1,R1,LSL#1).
  - Expect in order: loada with readnum=1; loadb with readnum=1; loadc with ALUop=00, shift=01; write with writenum=5, vsel=11.
  - 8 cycles total.
- CMP:
  - IR=A9A1.
  - Expect loads=1 exactly once, ALUop=01, no write and no loadc.
  - Next FETCH1 on cycle 8.
- LDR then STR:
  - LDR R3,[R1,#2] with datapath_out=0007 at LDA: expect mem_addr=07 in RD1/RD2, write with writenum=3 and vsel=00 in RD2.
  - STR: expect exactly one mem_write cycle with mem_addr=DAR.
- HALT, reset and wrap:
  - Memory[0]=E000: expect halted=1 from cycle 5 and no memory commands for 20+ cycles.
  - Pulse rst_n low mid-ADD: all strobes drop immediately, then restart fetch at 00.
  - Run 256 NOPs: PC wraps FF→00.
